// File: rtl/seg_scan_reader_if.sv
// Multiplexed 7-segment display bus: active-low segments and active-low one-hot anodes.
// The display driver is the master; the scan reader listens as the slave.
interface seg_scan_reader_if;
    logic [6:0] seg_in;
    logic [3:0] an_in;

    modport master (output seg_in, output an_in);
    modport slave  (input  seg_in, input  an_in);
endinterface

// File: rtl/seg_scan_reader.sv
// Recovers 4-digit frames from a multiplexed 7-segment bus and converts them to binary.
// A bus pattern is accepted once, after it has been stable for SETTLE cycles.
module seg_scan_reader #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    seg_scan_reader_if.slave    bus,
    output logic [15:0]         digits,
    output logic                frame_valid,
    output logic                frame_change,
    output logic [13:0]         bin_out,
    output logic                neg,
    output logic                bin_ok,
    output logic                stale,
    output logic                anode_err
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [6:0]    r_seg, r_seg_d;
    logic [3:0]    r_an, r_an_d;
    logic [CW-1:0] r_cnt;
    logic          r_acc;
    logic [3:0]    r_seen;
    logic [15:0]   r_slots;
    logic [TW-1:0] r_tmo;

    logic          w_same;
    logic [CW-1:0] w_cnt;
    logic [2:0]    w_low_cnt;
    logic          w_onehot;
    logic          w_multi;
    logic          w_accept;
    logic [1:0]    w_idx;
    logic [3:0]    w_code;
    logic          w_frame_done;
    logic [3:0]    w_seen_next;
    logic [13:0]   w_bin;
    logic          w_neg;
    logic          w_ok;

    function automatic logic [3:0] f_decode(input logic [6:0] s);
        case (s)
            7'b1000000: f_decode = 4'h0;
            7'b1111001: f_decode = 4'h1;
            7'b0100100: f_decode = 4'h2;
            7'b0110000: f_decode = 4'h3;
            7'b0011001: f_decode = 4'h4;
            7'b0010010: f_decode = 4'h5;
            7'b0000010: f_decode = 4'h6;
            7'b1111000: f_decode = 4'h7;
            7'b0000000: f_decode = 4'h8;
            7'b0010000: f_decode = 4'h9;
            7'b1111111: f_decode = 4'hA;
            7'b0111111: f_decode = 4'hB;
            default:    f_decode = 4'hF;
        endcase
    endfunction

    // Blank, minus and invalid codes all contribute zero to the binary value.
    function automatic logic [13:0] f_val(input logic [3:0] c);
        f_val = (c <= 4'd9) ? {10'd0, c} : 14'd0;
    endfunction

    assign w_same    = (r_seg == r_seg_d) && (r_an == r_an_d);
    assign w_low_cnt = 3'($countones(~r_an));
    assign w_onehot  = (w_low_cnt == 3'd1);
    assign w_multi   = (w_low_cnt >= 3'd2);
    assign w_code    = f_decode(r_seg);

    always_comb begin
        w_cnt = CW'(1);
        if (w_same) begin
            if (r_cnt == CW'(SETTLE)) w_cnt = r_cnt;
            else                      w_cnt = CW'(r_cnt + 1'b1);
        end
    end

    always_comb begin
        w_idx = 2'd0;
        case (r_an)
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    assign w_accept     = w_onehot && (w_cnt == CW'(SETTLE)) && !(w_same && r_acc);
    assign w_frame_done = (r_seen == 4'b1111);

    always_comb begin
        w_seen_next = w_frame_done ? 4'b0000 : r_seen;
        if (w_accept) w_seen_next[w_idx] = 1'b1;
    end

    always_comb begin
        w_bin = f_val(r_slots[15:12]) * 14'd1000 + f_val(r_slots[11:8]) * 14'd100
              + f_val(r_slots[7:4]) * 14'd10 + f_val(r_slots[3:0]);
        w_neg = 1'b0;
        w_ok  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (r_slots[i*4 +: 4] == 4'hB) w_neg = 1'b1;
            if (r_slots[i*4 +: 4] == 4'hF) w_ok  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg        <= 7'h7F;
            r_an         <= 4'hF;
            r_seg_d      <= 7'h7F;
            r_an_d       <= 4'hF;
            r_cnt        <= '0;
            r_acc        <= 1'b0;
            r_seen       <= 4'b0000;
            r_slots      <= 16'hAAAA;
            r_tmo        <= '0;
            digits       <= 16'hAAAA;
            bin_out      <= 14'd0;
            neg          <= 1'b0;
            bin_ok       <= 1'b0;
            frame_valid  <= 1'b0;
            frame_change <= 1'b0;
            anode_err    <= 1'b0;
        end else begin
            r_seg        <= bus.seg_in;
            r_an         <= bus.an_in;
            r_seg_d      <= r_seg;
            r_an_d       <= r_an;
            r_cnt        <= w_cnt;
            r_acc        <= (w_same & r_acc) | w_accept;
            r_seen       <= w_seen_next;
            frame_valid  <= 1'b0;
            frame_change <= 1'b0;
            if (w_multi) anode_err <= 1'b1;
            if (w_accept) r_slots[{w_idx, 2'b00} +: 4] <= w_code;
            if (w_frame_done) begin
                digits       <= r_slots;
                bin_out      <= w_bin;
                neg          <= w_neg;
                bin_ok       <= w_ok;
                frame_valid  <= 1'b1;
                frame_change <= (r_slots != digits);
                r_tmo        <= '0;
            end else if (r_tmo != TW'(TIMEOUT)) begin
                r_tmo <= TW'(r_tmo + 1'b1);
            end
        end
    end

    assign stale = (r_tmo == TW'(TIMEOUT));
endmodule

// File: tb/tb_seg_scan_reader.sv
// Scoreboard bench for seg_scan_reader: expected frames are queued as they are driven
// and compared whenever the reader reports a completed frame.
module tb_seg_scan_reader;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits;
    logic        frame_valid, frame_change, neg, bin_ok, stale, anode_err;
    logic [13:0] bin_out;

    seg_scan_reader_if bus ();

    seg_scan_reader #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .digits       (digits),
        .frame_valid  (frame_valid),
        .frame_change (frame_change),
        .bin_out      (bin_out),
        .neg          (neg),
        .bin_ok       (bin_ok),
        .stale        (stale),
        .anode_err    (anode_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dg;
        logic [13:0] bin;
        logic        neg;
        logic        ok;
        logic        chg;
    } exp_t;

    exp_t        q_exp[$];
    logic [15:0] last_dg = 16'hAAAA;
    int          n_checks = 0;
    int          n_err = 0;
    int          n_fv = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] c);
        case (c)
            4'h0: enc = 7'b1000000;
            4'h1: enc = 7'b1111001;
            4'h2: enc = 7'b0100100;
            4'h3: enc = 7'b0110000;
            4'h4: enc = 7'b0011001;
            4'h5: enc = 7'b0010010;
            4'h6: enc = 7'b0000010;
            4'h7: enc = 7'b1111000;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0010000;
            4'hA: enc = 7'b1111111;
            4'hB: enc = 7'b0111111;
            default: enc = 7'b0101010;
        endcase
    endfunction

    task automatic push_exp(input logic [15:0] dg);
        exp_t e;
        int   pw[4] = '{1, 10, 100, 1000};
        int   acc = 0;
        logic [3:0] d;
        e.neg = 1'b0;
        e.ok  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = dg[i*4 +: 4];
            if (d <= 4'd9) acc += int'(d) * pw[i];
            if (d == 4'hB) e.neg = 1'b1;
            if (d == 4'hF) e.ok  = 1'b0;
        end
        e.dg  = dg;
        e.bin = 14'(acc);
        e.chg = (dg != last_dg);
        last_dg = dg;
        q_exp.push_back(e);
    endtask

    task automatic hold_pat(input logic [6:0] s, input logic [3:0] a, input int n);
        @(negedge clk);
        bus.seg_in = s;
        bus.an_in  = a;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic drive_digit(input int pos, input logic [6:0] s, input int hold, input int gap);
        logic [3:0] a;
        a = 4'b0001 << pos;
        hold_pat(s, ~a, hold);
        if (gap > 0) hold_pat(7'h7F, 4'hF, gap);
    endtask

    task automatic drive_frame(input logic [15:0] dg, input int hold, input int gap);
        logic [15:0] v;
        v = dg;
        push_exp(dg);
        for (int p = 3; p >= 0; p--) drive_digit(p, enc(v[p*4 +: 4]), hold, gap);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_dg = 16'hAAAA;
    endtask

    always @(negedge clk) begin
        if (!rst && frame_valid) begin
            exp_t e;
            n_fv++;
            if (q_exp.size() == 0) begin
                chk("unexpected_frame_valid", 32'd1, 32'd0);
            end else begin
                e = q_exp.pop_front();
                chk("digits",       {16'd0, digits},     {16'd0, e.dg});
                chk("bin_out",      {18'd0, bin_out},    {18'd0, e.bin});
                chk("neg",          {31'd0, neg},        {31'd0, e.neg});
                chk("bin_ok",       {31'd0, bin_ok},     {31'd0, e.ok});
                chk("frame_change", {31'd0, frame_change}, {31'd0, e.chg});
            end
        end
    end

    initial begin
        int fv0;
        bus.seg_in = 7'h7F;
        bus.an_in  = 4'hF;
        do_reset();
        @(negedge clk);
        chk("rst_digits",      {16'd0, digits},  32'h0000AAAA);
        chk("rst_bin_out",     {18'd0, bin_out}, 32'd0);
        chk("rst_neg",         {31'd0, neg},     32'd0);
        chk("rst_bin_ok",      {31'd0, bin_ok},  32'd0);
        chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst_frame_change",{31'd0, frame_change}, 32'd0);
        chk("rst_stale",       {31'd0, stale},   32'd0);
        chk("rst_anode_err",   {31'd0, anode_err}, 32'd0);

        // T1
        drive_frame(16'h9998, 8, 2);

        // T2: holds one cycle short of SETTLE never settle
        chk("t2_stale_before", {31'd0, stale}, 32'd0);
        fv0 = n_fv;
        for (int i = 0; i < 1400; i++) drive_digit(i % 4, enc(4'h5), SETTLE - 1, 0);
        chk("t2_no_frame", n_fv - fv0, 32'd0);
        chk("t2_stale_after", {31'd0, stale}, 32'd1);

        // T3 with hold of exactly SETTLE cycles
        drive_frame(16'hB321, SETTLE, 2);
        chk("t3_stale_cleared", {31'd0, stale}, 32'd0);

        // T4
        push_exp(16'h123F);
        drive_digit(3, enc(4'h1), 8, 2);
        drive_digit(2, enc(4'h2), 8, 2);
        drive_digit(1, enc(4'h3), 8, 2);
        drive_digit(0, 7'b0101010, 8, 2);
        repeat (4) @(negedge clk);
        chk("t4_anode_err_clear", {31'd0, anode_err}, 32'd0);
        fv0 = n_fv;
        hold_pat(7'h7F, 4'b1100, 10);
        hold_pat(7'h7F, 4'hF, 3);
        chk("t4_anode_err_set", {31'd0, anode_err}, 32'd1);
        chk("t4_no_frame", n_fv - fv0, 32'd0);

        // T5
        drive_frame(16'h9998, 8, 2);
        drive_frame(16'h9998, 8, 2);
        drive_frame(16'h9997, 8, 2);
        chk("t5_anode_err_sticky", {31'd0, anode_err}, 32'd1);

        // T6: reset discards a partial frame
        drive_digit(3, enc(4'h0), 8, 2);
        drive_digit(2, enc(4'h0), 8, 2);
        do_reset();
        @(negedge clk);
        chk("t6_rst_anode_err", {31'd0, anode_err}, 32'd0);
        chk("t6_rst_digits", {16'd0, digits}, 32'h0000AAAA);
        fv0 = n_fv;
        drive_frame(16'h0042, 8, 2);
        repeat (10) @(negedge clk);
        chk("t6_one_frame", n_fv - fv0, 32'd1);

        chk("queue_drained", q_exp.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
